// File: rtl/scsi_dma_fifo.sv
// scsi_dma_fifo: 8 x 32-bit longword FIFO between the SCSI byte engine and the
// CPU/DMA bus. The SCSI side writes and reads single byte lanes under a 2-bit
// byte pointer (BO). The bus side writes whole longwords under byte enables and
// reads whole longwords. Status flags are decoded from registered state.
module scsi_dma_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CPUCLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  INCNI,
    input  logic                  INCNO,
    input  logic                  INCBO,
    input  logic                  LBYTE_,
    input  logic [7:0]            SCSI_ID,
    input  logic                  LLWORD,
    input  logic [3:0]            BE,
    input  logic [31:0]           BUS_ID,
    output logic [31:0]           BUS_OD,
    output logic [7:0]            SCSI_OD,
    output logic [1:0]            BO,
    output logic                  BOEQ0,
    output logic                  BOEQ3,
    output logic                  FIFOEMPTY,
    output logic                  FIFOFULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVR,
    output logic                  UNR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = {DEPTH_LOG2{1'b0}};

    // Big-endian lane mapping: BO=0 addresses bits 31:24, BO=3 bits 7:0.
    // Returns the one-hot lane write mask (bit k covers bits 8k+7:8k).
    function automatic logic [3:0] lane_onehot(input logic [1:0] bo);
        logic [3:0] mask;
        case (bo)
            2'd0:    mask = 4'b1000;
            2'd1:    mask = 4'b0100;
            2'd2:    mask = 4'b0010;
            2'd3:    mask = 4'b0001;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Selects the byte lane addressed by the byte pointer, same mapping as above.
    function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] bo);
        logic [7:0] lane;
        case (bo)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            2'd3:    lane = word[7:0];
            default: lane = 8'h00;
        endcase
        return lane;
    endfunction

    // Registered state
    logic [DEPTH_LOG2-1:0] ni_r;
    logic [DEPTH_LOG2-1:0] no_r;
    logic [1:0]            bo_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  ovr_r;
    logic                  unr_r;
    logic [31:0]           mem_r [DEPTH];

    // Next-state and write-path signals
    logic [DEPTH_LOG2-1:0] ni_nxt_s;
    logic [DEPTH_LOG2-1:0] no_nxt_s;
    logic [1:0]            bo_nxt_s;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic                  ovr_nxt_s;
    logic                  unr_nxt_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [3:0]            lane_we_s;
    logic [31:0]           lane_data_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);

    // A push is refused only when full and a pop only when empty. Treating the
    // two independently gives the simultaneous-strobe behaviour directly:
    // empty -> push only, full -> pop only, otherwise both pointers move.
    assign push_ok_s = INCNI & ~full_s;
    assign pop_ok_s  = INCNO & ~empty_s;

    // Pointer, count, byte-pointer and sticky-error next-state decode.
    always_comb begin
        ni_nxt_s    = ni_r;
        no_nxt_s    = no_r;
        bo_nxt_s    = bo_r;
        count_nxt_s = count_r;
        ovr_nxt_s   = ovr_r;
        unr_nxt_s   = unr_r;

        if (push_ok_s) begin
            ni_nxt_s = ni_r + PTR_ONE;
        end else begin
            ni_nxt_s = ni_r;
        end

        if (pop_ok_s) begin
            no_nxt_s = no_r + PTR_ONE;
        end else begin
            no_nxt_s = no_r;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (INCBO) begin
            bo_nxt_s = bo_r + 2'd1;
        end else begin
            bo_nxt_s = bo_r;
        end

        ovr_nxt_s = ovr_r | (INCNI & full_s);
        unr_nxt_s = unr_r | (INCNO & empty_s);
    end

    // Write-lane decode: a longword write overrides a byte write in the same
    // cycle; reset and flush cycles discard all strobes including writes.
    always_comb begin
        lane_we_s   = 4'b0000;
        lane_data_s = BUS_ID;
        if (RESET || FLUSH) begin
            lane_we_s   = 4'b0000;
            lane_data_s = BUS_ID;
        end else if (LLWORD) begin
            lane_we_s   = BE;
            lane_data_s = BUS_ID;
        end else if (!LBYTE_) begin
            lane_we_s   = lane_onehot(bo_r);
            lane_data_s = {4{SCSI_ID}};
        end else begin
            lane_we_s   = 4'b0000;
            lane_data_s = BUS_ID;
        end
    end

    // Control state register with synchronous reset; flush has the same effect.
    always_ff @(posedge CPUCLK) begin
        if (RESET) begin
            ni_r    <= PTR_ZERO;
            no_r    <= PTR_ZERO;
            bo_r    <= 2'd0;
            count_r <= CNT_ZERO;
            ovr_r   <= 1'b0;
            unr_r   <= 1'b0;
        end else if (FLUSH) begin
            ni_r    <= PTR_ZERO;
            no_r    <= PTR_ZERO;
            bo_r    <= 2'd0;
            count_r <= CNT_ZERO;
            ovr_r   <= 1'b0;
            unr_r   <= 1'b0;
        end else begin
            ni_r    <= ni_nxt_s;
            no_r    <= no_nxt_s;
            bo_r    <= bo_nxt_s;
            count_r <= count_nxt_s;
            ovr_r   <= ovr_nxt_s;
            unr_r   <= unr_nxt_s;
        end
    end

    // Storage array: per-lane writes into the entry at the current write
    // pointer (before any same-cycle advance). Contents are never reset.
    always_ff @(posedge CPUCLK) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we_s[k]) begin
                mem_r[ni_r][8*k +: 8] <= lane_data_s[8*k +: 8];
            end
        end
    end

    // Read side has no bypass: outputs show storage as of the previous edge.
    assign BUS_OD    = mem_r[no_r];
    assign SCSI_OD   = lane_select(mem_r[no_r], bo_r);

    assign BO        = bo_r;
    assign BOEQ0     = (bo_r == 2'd0);
    assign BOEQ3     = (bo_r == 2'd3);
    assign FIFOEMPTY = empty_s;
    assign FIFOFULL  = full_s;
    assign COUNT     = count_r;
    assign OVR       = ovr_r;
    assign UNR       = unr_r;

endmodule
